// File: rtl/prbs15_checker.sv
// PRBS-15 receive checker: self-synchronises a local LFSR, then free-runs and counts bit errors.
// Lock is dropped when the errors within one observation window reach the loss threshold.
module prbs15_checker #(
    parameter int Type       = 15,
    parameter int ErrWidth   = 16,
    parameter int LockCount  = 32,
    parameter int WinLen     = 64,
    parameter int LossThresh = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                InBit,
    input  logic                InValid,
    input  logic                ClrCnt,
    output logic                Locked,
    output logic                ErrPulse,
    output logic [ErrWidth-1:0] ErrCount,
    output logic [1:0]          State
);

    localparam int FillW  = $clog2(Type + 1);
    localparam int MatchW = $clog2(LockCount + 1);
    localparam int WinW   = $clog2(WinLen);
    localparam int WerrW  = $clog2(LossThresh + 1);

    localparam logic [FillW-1:0]  FillLast  = FillW'(Type - 1);
    localparam logic [MatchW-1:0] MatchLast = MatchW'(LockCount - 1);
    localparam logic [WinW-1:0]   WinLast   = WinW'(WinLen - 1);
    localparam logic [WerrW-1:0]  LossLevel = WerrW'(LossThresh);

    localparam logic [1:0] FILL   = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [Type-1:0]     hist_q, hist_d;
    logic [FillW-1:0]    fill_q, fill_d;
    logic [MatchW-1:0]   match_q, match_d;
    logic [WinW-1:0]     win_q, win_d;
    logic [WerrW-1:0]    werr_q, werr_d;
    logic [ErrWidth-1:0] err_cnt_q, err_cnt_d;
    logic                err_pulse_q, err_pulse_d;

    logic                pred;
    logic                mismatch;
    logic [WerrW-1:0]    werr_inc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hist_q      <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_q       <= '0;
            werr_q      <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_q       <= win_d;
            werr_q      <= werr_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    always_comb begin
        pred        = hist_q[Type-2] ^ hist_q[Type-1];
        mismatch    = InBit ^ pred;
        werr_inc    = werr_q + WerrW'(mismatch);
        state_d     = state_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_d       = win_q;
        werr_d      = werr_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;

        if (InValid) begin
            case (state_q)
                VERIFY: begin
                    hist_d = {hist_q[Type-2:0], InBit};
                    // An all-zero history predicts zeros forever, so it never counts as a match.
                    if (!mismatch && (hist_q != '0)) begin
                        if (match_q == MatchLast) begin
                            state_d = LOCKED;
                            match_d = '0;
                            win_d   = '0;
                            werr_d  = '0;
                        end else begin
                            match_d = match_q + MatchW'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    hist_d = {hist_q[Type-2:0], pred};
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ErrWidth'(1);
                        end
                    end
                    if (werr_inc >= LossLevel) begin
                        state_d = FILL;
                        fill_d  = '0;
                    end else if (win_q == WinLast) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d  = win_q + WinW'(1);
                        werr_d = werr_inc;
                    end
                end
                default: begin
                    hist_d = {hist_q[Type-2:0], InBit};
                    if (fill_q == FillLast) begin
                        state_d = VERIFY;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + FillW'(1);
                    end
                end
            endcase
        end

        if (ClrCnt) begin
            err_cnt_d = '0;
        end
    end

    always_comb begin
        Locked   = (state_q == LOCKED);
        State    = (state_q == 2'd3) ? FILL : state_q;
        ErrPulse = err_pulse_q;
        ErrCount = err_cnt_q;
    end

endmodule

// File: tb/tb_prbs15_checker.sv
// Directed bench for prbs15_checker: lock, single errors, loss/re-lock, saturation, gaps, resets.
// A 4-bit-counter instance shares all inputs to exercise ErrCount saturation.
module tb_prbs15_checker;

    logic        CLK = 1'b0;
    logic        RST, InBit, InValid, ClrCnt;
    logic        Locked, ErrPulse, Locked4, ErrPulse4;
    logic [15:0] ErrCount;
    logic [3:0]  ErrCount4;
    logic [1:0]  State, State4;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [14:0] g;

    prbs15_checker u_dut (
        .CLK(CLK), .RST(RST), .InBit(InBit), .InValid(InValid), .ClrCnt(ClrCnt),
        .Locked(Locked), .ErrPulse(ErrPulse), .ErrCount(ErrCount), .State(State)
    );

    prbs15_checker #(.ErrWidth(4)) u_dut4 (
        .CLK(CLK), .RST(RST), .InBit(InBit), .InValid(InValid), .ClrCnt(ClrCnt),
        .Locked(Locked4), .ErrPulse(ErrPulse4), .ErrCount(ErrCount4), .State(State4)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic b, input logic v, input logic clr);
        @(negedge CLK);
        InBit   = b;
        InValid = v;
        ClrCnt  = clr;
        @(posedge CLK);
        #1;
    endtask

    // Reference generator: x^15 + x^14 + 1, newest bit in g[0].
    task automatic gen_bit(output logic b);
        b = g[14] ^ g[13];
        g = {g[13:0], b};
    endtask

    task automatic gbit(input logic flip);
        logic b;
        gen_bit(b);
        send(b ^ flip, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; InValid = 1'b0; ClrCnt = 1'b0; InBit = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        logic b;
        int   nv;
        int   cyc;

        RST = 1'b1; InBit = 1'b0; InValid = 1'b0; ClrCnt = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_locked", {15'd0, Locked}, 16'd0);
        check("rst_pulse", {15'd0, ErrPulse}, 16'd0);
        check("rst_count", ErrCount, 16'd0);
        check("rst_state", {14'd0, State}, 16'd0);
        RST = 1'b0;

        // Clean stream from seed 0x2ABC: fill 15, verify 32, lock on valid bit 47.
        g = 15'h2ABC;
        for (int i = 1; i <= 47; i++) begin
            gbit(1'b0);
            if (i == 14) check("fill_state_14", {14'd0, State}, 16'd0);
            if (i == 15) check("verify_state_15", {14'd0, State}, 16'd1);
            if (i == 46) check("unlocked_46", {15'd0, Locked}, 16'd0);
        end
        check("locked_47", {15'd0, Locked}, 16'd1);
        check("locked_state", {14'd0, State}, 16'd2);
        check("lock_count", ErrCount, 16'd0);
        check("locked4_47", {15'd0, Locked4}, 16'd1);

        // Single corrupted bit: exactly one pulse and one count.
        repeat (10) gbit(1'b0);
        gbit(1'b1);
        check("single_pulse", {15'd0, ErrPulse}, 16'd1);
        check("single_count", ErrCount, 16'd1);
        check("single_locked", {15'd0, Locked}, 16'd1);
        gbit(1'b0);
        check("single_pulse_gone", {15'd0, ErrPulse}, 16'd0);
        check("single_count_hold", ErrCount, 16'd1);

        // 12 bits used in the first window; finish it so the next starts clean.
        repeat (52) gbit(1'b0);
        check("win1_locked", {15'd0, Locked}, 16'd1);

        // Eight errors within one window: loss on the eighth.
        for (int k = 1; k <= 8; k++) begin
            gbit(1'b1);
            if (k < 8) begin
                check("loss_still_locked", {15'd0, Locked}, 16'd1);
                gbit(1'b0);
            end
        end
        check("loss_locked", {15'd0, Locked}, 16'd0);
        check("loss_state", {14'd0, State}, 16'd0);
        check("loss_pulse", {15'd0, ErrPulse}, 16'd1);
        check("loss_count", ErrCount, 16'd9);

        for (int i = 1; i <= 47; i++) begin
            gbit(1'b0);
            if (i == 46) check("relock_46", {15'd0, Locked}, 16'd0);
        end
        check("relock_47", {15'd0, Locked}, 16'd1);
        check("relock_count_held", ErrCount, 16'd9);

        // Clear during an invalid cycle; nothing else may move.
        send(1'b1, 1'b0, 1'b1);
        check("clr_invalid_count", ErrCount, 16'd0);
        check("clr_invalid_count4", {12'd0, ErrCount4}, 16'd0);
        check("invalid_pulse", {15'd0, ErrPulse}, 16'd0);
        check("invalid_state", {14'd0, State}, 16'd2);

        // Seven errors per window for ten windows: stays locked; 4-bit counter saturates.
        for (int w = 0; w < 10; w++) begin
            for (int pos = 0; pos < 64; pos++) gbit(pos < 7);
            check("win_locked", {15'd0, Locked}, 16'd1);
            if (w == 1) check("sat4_14", {12'd0, ErrCount4}, 16'd14);
            if (w == 2) begin
                check("sat4_15", {12'd0, ErrCount4}, 16'd15);
                check("count_21", ErrCount, 16'd21);
            end
        end
        check("count_70", ErrCount, 16'd70);
        check("sat4_final", {12'd0, ErrCount4}, 16'd15);

        // Clear wins over a simultaneous error.
        gen_bit(b);
        send(~b, 1'b1, 1'b1);
        check("clr_err_pulse", {15'd0, ErrPulse}, 16'd1);
        check("clr_err_count", ErrCount, 16'd0);
        check("clr_err_count4", {12'd0, ErrCount4}, 16'd0);

        // Asynchronous reset mid-LOCKED, observed before any clock edge.
        gbit(1'b1);
        check("pre_rst_count", ErrCount, 16'd1);
        #2 RST = 1'b1;
        #1;
        check("arst_locked", {15'd0, Locked}, 16'd0);
        check("arst_pulse", {15'd0, ErrPulse}, 16'd0);
        check("arst_count", ErrCount, 16'd0);
        check("arst_state", {14'd0, State}, 16'd0);
        @(negedge CLK);
        RST = 1'b0; InValid = 1'b0;

        // Scenario-1 stream with random InValid gaps: lock after exactly 47 valid bits.
        g   = 15'h2ABC;
        nv  = 0;
        cyc = 0;
        while (nv < 47 && cyc < 2000) begin
            cyc++;
            if ($urandom_range(0, 1) == 1) begin
                gen_bit(b);
                send(b, 1'b1, 1'b0);
                nv++;
            end else begin
                send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end
            check("gap_no_pulse", {15'd0, ErrPulse}, 16'd0);
            check("gap_locked", {15'd0, Locked}, {15'd0, (nv >= 47)});
        end
        check("gap_budget", nv[15:0], 16'd47);

        // All-zero stream must never lock.
        do_reset();
        for (int i = 1; i <= 500; i++) begin
            send(1'b0, 1'b1, 1'b0);
            if (i == 15) check("zero_verify", {14'd0, State}, 16'd1);
            if (Locked !== 1'b0) check("zero_never_locked", {15'd0, Locked}, 16'd0);
        end
        check("zero_end_state", {14'd0, State}, 16'd1);
        check("zero_end_locked", {15'd0, Locked}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
